// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by uart_tx and the matching receiver.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state for 8E1 framing).
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 4;
    localparam int FIFO_DEPTH_DEFAULT   = 4;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte-level valid/ready handshake into the transmitter.
// master = byte producer, slave = uart_tx.
interface uart_tx_if;
    import uart_pkg::*;

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO, power-of-two depth, pointers carry one extra
// wrap bit so full and empty are distinguishable. Head is visible combinationally
// so the transmitter can load it on the same edge it pops.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg[AW-1:0]];

    // Storage write; a push coinciding with reset never lands.
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; push and pop in the same cycle both advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + {{AW{1'b0}}, 1'b1};
            end
        end
    end
endmodule

// File: rtl/uart_tx.sv
// uart_tx: buffered UART transmitter, 8N1 by default, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit after data bit 7 (8E1).
// Back-to-back frames leave no idle cycle between a stop bit and the next start bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    uart_tx_if.slave     bus,
    output logic         tx,
    output logic         busy
);
    localparam int BW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(DATA_BITS - 1);

    uart_state_t          state_reg,   state_next;
    logic [BW-1:0]        baud_reg,    baud_next;
    logic [IDX_W-1:0]     bit_idx_reg, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg,   shift_next;
    logic                 tx_reg,      tx_next;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg,  parity_next;
`endif

    logic                 bit_end;
    logic                 load;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.tx_valid),
        .push_data (bus.tx_data),
        .pop       (load),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bus.tx_ready = !fifo_full;
    assign busy         = (state_reg != IDLE) || !fifo_empty;
    assign tx           = tx_reg;
    assign bit_end      = (baud_reg == BAUD_LAST);

    // Next-state, baud/bit counters and the registered line level for the next cycle.
    always_comb begin
        state_next   = state_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        load         = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next  = parity_reg;
`endif
        if (state_reg == IDLE || bit_end) begin
            baud_next = '0;
        end else begin
            baud_next = baud_reg + {{(BW-1){1'b0}}, 1'b1};
        end

        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                load    = !fifo_empty;
            end
            START: begin
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_next = PARITY;
                        tx_next    = parity_reg;
`else
                        state_next = STOP;
                        tx_next    = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};
                        shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
                        tx_next      = shift_reg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next = STOP;
                    tx_next    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    load       = !fifo_empty;
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                tx_next    = 1'b1;
            end
        endcase

        // Popping the head starts a new frame immediately, from IDLE or straight out of STOP.
        if (load) begin
            state_next = START;
            shift_next = fifo_head;
            tx_next    = 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^fifo_head;
`endif
        end
    end

    // State and datapath registers; reset aborts any frame and returns the line high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            baud_reg    <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            baud_reg    <= baud_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= parity_next;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a frame-level reference model,
// per-cycle compare of tx/busy/tx_ready, literal frame checks and a serial decoder.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;

    uart_tx_if bus ();

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: queue of accepted bytes plus the bit array of the frame on the line.
    logic [7:0]   m_q[$];
    logic [7:0]   sent_q[$];
    bit           m_active = 1'b0;
    int           m_t = 0;
    bit [NB-1:0]  m_frame = '1;
    logic         exp_tx = 1'b1;
    logic         exp_busy = 1'b0;
    logic         exp_ready = 1'b1;
    bit           chk_en = 1'b0;
    bit           rx_en = 1'b0;
    int           rx_count = 0;

    function automatic bit [NB-1:0] frame_of(input logic [7:0] b);
        bit [NB-1:0] f;
        f = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
        f[9] = ^b;
`endif
        return f;
    endfunction

    initial begin
        bit         do_push;
        logic [7:0] pd;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_q.delete();
                m_active = 1'b0;
                m_t      = 0;
                chk_en   = 1'b1;
            end else begin
                do_push = bus.tx_valid && (m_q.size() < DEPTH);
                pd      = bus.tx_data;
                if (m_active && m_t < FL - 1) begin
                    m_t++;
                end else if (m_q.size() > 0) begin
                    m_frame  = frame_of(m_q.pop_front());
                    m_t      = 0;
                    m_active = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
                if (do_push) begin
                    m_q.push_back(pd);
                    if (rx_en) sent_q.push_back(pd);
                end
            end
            exp_tx    = m_active ? m_frame[m_t / CPB] : 1'b1;
            exp_busy  = m_active || (m_q.size() > 0);
            exp_ready = (m_q.size() < DEPTH);
        end
    end

    // Per-cycle compare of DUT outputs against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("tx", 32'(tx), 32'(exp_tx));
                check("busy", 32'(busy), 32'(exp_busy));
                check("tx_ready", 32'(bus.tx_ready), 32'(exp_ready));
            end
        end
    end

    // Serial decoder: samples mid-bit and checks each received byte against acceptance order.
    initial begin
        logic [NB-1:0] f;
        logic [7:0]    want;
        forever begin
            @(negedge clk);
            if (rx_en && tx === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int k = 0; k < NB; k++) begin
                    f[k] = tx;
                    if (k < NB - 1) repeat (CPB) @(negedge clk);
                end
                want = 8'h00;
                if (sent_q.size() > 0) want = sent_q.pop_front();
                check("rx_byte", 32'(f[8:1]), 32'(want));
                check("rx_start", 32'(f[0]), 32'd0);
                check("rx_stop", 32'(f[NB-1]), 32'd1);
`ifdef UART_TX_PARITY_EN
                check("rx_parity", 32'(f[9]), 32'(^f[8:1]));
`endif
                rx_count++;
            end
        end
    end

    task automatic push(input logic [7:0] b, output int waited);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        waited = 0;
        while (bus.tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 2000) check("push_timeout", 32'(bus.tx_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic release_bus();
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'hFF;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (busy === 1'b1 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Waits for the start bit, then samples every bit mid-period.
    task automatic capture(output logic [15:0] cap, output int lat);
        cap = '0;
        lat = 0;
        while (tx !== 1'b0 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        repeat (CPB / 2) @(negedge clk);
        for (int k = 0; k < NB; k++) begin
            cap[k] = tx;
            if (k < NB - 1) repeat (CPB) @(negedge clk);
        end
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        int          w;
        int          lat;
        int          c;
        int          bad;
        logic [15:0] cap;

        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ready", 32'(bus.tx_ready), 32'd1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0x04: line levels, start latency, idle afterwards.
        push(8'h04, w);
        release_bus();
        capture(cap, lat);
        check("latency_04", 32'(lat), 32'd1);
`ifdef UART_TX_PARITY_EN
        check("frame_04", 32'(cap), 32'h608);
`else
        check("frame_04", 32'(cap), 32'h208);
`endif
        check("after_04_busy", 32'(busy), 32'd0);
        check("after_04_tx", 32'(tx), 32'd1);

        // 0x07 and 0x03: parity 1 and parity 0 when enabled.
        push(8'h07, w);
        release_bus();
        capture(cap, lat);
`ifdef UART_TX_PARITY_EN
        check("frame_07", 32'(cap), 32'h60E);
`else
        check("frame_07", 32'(cap), 32'h20E);
`endif
        push(8'h03, w);
        release_bus();
        capture(cap, lat);
`ifdef UART_TX_PARITY_EN
        check("frame_03", 32'(cap), 32'h406);
`else
        check("frame_03", 32'(cap), 32'h206);
`endif
        wait_idle();

        // Three consecutive pushes: no stalls, frames abut exactly.
        push(8'h07, w);
        check("b2b_ready_0", 32'(w), 32'd0);
        push(8'h02, w);
        check("b2b_ready_1", 32'(w), 32'd0);
        push(8'h03, w);
        check("b2b_ready_2", 32'(w), 32'd0);
        release_bus();
        c = 0;
        while (busy === 1'b1 && c < 1000) begin
            @(negedge clk);
            c++;
        end
        check("b2b_length", 32'(c), 32'(3 * FL - 1));
        wait_idle();

        // Fill the buffer behind a busy line; the 5th byte waits for the next pop.
        push(8'h55, w);
        push(8'h0E, w);
        push(8'h1B, w);
        push(8'h63, w);
        push(8'h7B, w);
        check("full_after_4", 32'(bus.tx_ready), 32'd0);
        push(8'h01, w);
        check("fifth_wait", 32'(w), 32'(FL - 3));
        release_bus();
        wait_idle();

        // Reset during data bit 3 of 0x63 with two bytes queued, push coinciding with reset.
        push(8'h63, w);
        push(8'h7B, w);
        push(8'h01, w);
        release_bus();
        repeat (16) @(negedge clk);
        rst = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 8'hAA;
        @(negedge clk);
        rst = 1'b0;
        release_bus();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(bus.tx_ready), 32'd1);
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rst_quiet", 32'(bad), 32'd0);

        // All byte values through the serial decoder.
        sent_q.delete();
        rx_count = 0;
        rx_en = 1'b1;
        for (int b = 0; b < 256; b++) begin
            push(8'(b), w);
        end
        release_bus();
        wait_idle();
        repeat (CPB) @(negedge clk);
        rx_en = 1'b0;
        check("rx_count", 32'(rx_count), 32'd256);
        check("rx_pending", 32'(sent_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
